// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
//
// Arbitrates a single downstream bus interface between two requesters:
// A (CPU) and B (debug/DMA). A three-state FSM (IDLE, OWN_A, OWN_B) owns the
// bus for one transaction at a time. The memory_* request outputs are
// registered, so requester inputs never reach them combinationally. The
// completion path (memory_done/memory_rdata -> x_done/x_rdata) is
// combinational so the requester sees its result in the same cycle.
//
// Configuration macro: BUS_ARBITER_ROUND_ROBIN_EN
//   defined   : 1-bit round-robin pointer favours the port not served last
//   undefined : fixed priority, A wins simultaneous requests
//
// Ports
//   clk, rst                         clock, asynchronous active-high reset
//   a_read/a_write/a_addr/a_wdata    requester A request (level, held to done)
//   a_rdata/a_done                   requester A read data / completion pulse
//   b_read/b_write/b_addr/b_wdata    requester B request (level, held to done)
//   b_rdata/b_done                   requester B read data / completion pulse
//   memory_read/write/addr/wdata     request to the bus interface
//   memory_rdata/memory_done         bus interface result / completion pulse
//   grant                            one-hot owner {B,A}, 2'b00 when idle
//   proto_err                        sticky: a requester drove read and write
// -----------------------------------------------------------------------------
module bus_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_read,
  input  logic        a_write,
  input  logic [15:0] a_addr,
  input  logic [7:0]  a_wdata,
  output logic [7:0]  a_rdata,
  output logic        a_done,
  input  logic        b_read,
  input  logic        b_write,
  input  logic [15:0] b_addr,
  input  logic [7:0]  b_wdata,
  output logic [7:0]  b_rdata,
  output logic        b_done,
  output logic        memory_read,
  output logic        memory_write,
  output logic [15:0] memory_addr,
  output logic [7:0]  memory_wdata,
  input  logic [7:0]  memory_rdata,
  input  logic        memory_done,
  output logic [1:0]  grant,
  output logic        proto_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [7:0]  mem_wdata_q, mem_wdata_d;
  logic [7:0]  a_rdata_q, a_rdata_d;
  logic [7:0]  b_rdata_q, b_rdata_d;
  logic        proto_err_q, proto_err_d;
  logic        a_req, b_req;
  logic        done_a, done_b;
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
  logic        ptr_q, ptr_d;  // 0: A favoured, 1: B favoured
`endif

  always_comb begin
    // NOTE: every signal written here gets a default first so no path
    // through the case statements can leave it unassigned (no latches).
    state_d     = state_q;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    mem_addr_d  = 16'h0000;
    mem_wdata_d = 8'h00;
    grant_d     = 2'b00;

    // Exactly one of read/write means a valid request; both is a protocol error.
    a_req = a_read ^ a_write;
    b_req = b_read ^ b_write;

    // Completion only counts for the current owner; done in IDLE is dropped.
    done_a = (state_q == OWN_A) && memory_done;
    done_b = (state_q == OWN_B) && memory_done;

    case (state_q)
      IDLE: begin
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
        if (a_req && b_req) state_d = ptr_q ? OWN_B : OWN_A;
        else if (a_req)     state_d = OWN_A;
        else if (b_req)     state_d = OWN_B;
`else
        if (a_req)      state_d = OWN_A;
        else if (b_req) state_d = OWN_B;
`endif
      end
      // Ownership is released only by memory_done: the bus transaction is
      // already in flight even if the owner drops its request.
      OWN_A:   if (memory_done) state_d = IDLE;
      OWN_B:   if (memory_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Request outputs are loaded from the next state so they line up with
    // grant. An owner driving read and write together forwards neither.
    case (state_d)
      OWN_A: begin
        grant_d     = 2'b01;
        mem_read_d  = a_read & ~a_write;
        mem_write_d = a_write & ~a_read;
        mem_addr_d  = a_addr;
        mem_wdata_d = a_wdata;
      end
      OWN_B: begin
        grant_d     = 2'b10;
        mem_read_d  = b_read & ~b_write;
        mem_write_d = b_write & ~b_read;
        mem_addr_d  = b_addr;
        mem_wdata_d = b_wdata;
      end
      default: ;
    endcase

    a_rdata_d   = done_a ? memory_rdata : a_rdata_q;
    b_rdata_d   = done_b ? memory_rdata : b_rdata_q;
    proto_err_d = proto_err_q | (a_read & a_write) | (b_read & b_write);

`ifdef BUS_ARBITER_ROUND_ROBIN_EN
    ptr_d = ptr_q;
    if (done_a) ptr_d = 1'b1;
    if (done_b) ptr_d = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= 2'b00;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= 16'h0000;
      mem_wdata_q <= 8'h00;
      a_rdata_q   <= 8'h00;
      b_rdata_q   <= 8'h00;
      proto_err_q <= 1'b0;
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
      ptr_q       <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge
      // values computed above, independent of statement order.
      state_q     <= state_d;
      grant_q     <= grant_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      a_rdata_q   <= a_rdata_d;
      b_rdata_q   <= b_rdata_d;
      proto_err_q <= proto_err_d;
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

  assign grant        = grant_q;
  assign memory_read  = mem_read_q;
  assign memory_write = mem_write_q;
  assign memory_addr  = mem_addr_q;
  assign memory_wdata = mem_wdata_q;
  assign a_done       = done_a;
  assign b_done       = done_b;
  // Read data is visible in the done cycle and held afterwards.
  assign a_rdata      = a_rdata_d;
  assign b_rdata      = b_rdata_d;
  assign proto_err    = proto_err_q;

endmodule
